// File: rtl/cic_sequencer_if.sv
// ---------------------------------------------------------------------------
// cic_sequencer_if
// Valid/ready channel that carries captured CIC filter words from the
// sequencer's one-entry buffer to downstream logic.
//   sample_data   captured filter word (source -> sink)
//   sample_valid  sample_data holds an unconsumed word (source -> sink)
//   sample_ready  sink accepts the word this cycle (sink -> source)
// A word transfers on a clock edge where sample_valid and sample_ready are
// both high.
// ---------------------------------------------------------------------------
interface cic_sequencer_if #(
  parameter int DATA_WIDTH = 25
);
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/cic_sequencer.sv
// ---------------------------------------------------------------------------
// cic_sequencer
// Sequences a third-order CIC decimator behind a sigma-delta modulator:
// clears the filter, generates the decimation strobe for D = 2^dec_log2,
// throws away the settling outputs after each start, and captures valid
// filter words into a one-entry buffer drained over a valid/ready channel.
//
// Ports
//   clk          modulator-rate clock
//   reset        synchronous, active-high reset
//   enable       level: high runs conversion, low aborts to IDLE
//   single_shot  1 = one word per start, 0 = continuous (latched at start)
//   dec_log2     decimation exponent (latched at start; 0 or out-of-range
//                selects MAX_DEC_LOG2)
//   cic_data     CIC filter output word
//   cic_clear    holds CIC integrators/combs cleared (registered)
//   dec_strobe   one-cycle pulse at each decimation boundary
//   smp          valid/ready output channel (master side)
//   overrun_clr  clears the sticky overrun flag
//   overrun      sticky: a capture was dropped because the buffer was full
//   busy         high in FLUSH, SETTLE and RUN
// ---------------------------------------------------------------------------
module cic_sequencer #(
  parameter  int MAX_DEC_LOG2   = 8,
  parameter  int DATA_WIDTH     = 3*MAX_DEC_LOG2+1,
  parameter  int SETTLE_SAMPLES = 3,
  localparam int LW             = $clog2(MAX_DEC_LOG2+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  single_shot,
  input  logic [LW-1:0]         dec_log2,
  input  logic [DATA_WIDTH-1:0] cic_data,
  output logic                  cic_clear,
  output logic                  dec_strobe,
  cic_sequencer_if.master       smp,
  input  logic                  overrun_clr,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = MAX_DEC_LOG2;                 // decimation counter width
  localparam int SW = $clog2(SETTLE_SAMPLES+1);     // settle strobe counter width

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         counter;
  logic [CW-1:0]         dec_mask;      // D-1 for the latched ratio
  logic [CW-1:0]         counter_step;
  logic [SW-1:0]         settle_cnt;
  logic [LW-1:0]         dec_lat;
  logic [LW-1:0]         dec_clamped;
  logic                  single_lat;
  logic                  capture_pending;
  logic                  cic_clear_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;

  // D-1 is a run of dec_lat ones; building it bit by bit avoids a wide shift.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    dec_mask = '0;
    for (int i = 0; i < CW; i++) dec_mask[i] = (LW'(i) < dec_lat);
  end

  assign dec_clamped  = (dec_log2 == '0 || dec_log2 > LW'(MAX_DEC_LOG2))
                        ? LW'(MAX_DEC_LOG2) : dec_log2;
  assign dec_strobe   = (state == S_SETTLE || state == S_RUN) && (counter == dec_mask);
  assign counter_step = dec_strobe ? '0 : counter + CW'(1);
  assign busy         = (state == S_FLUSH || state == S_SETTLE || state == S_RUN);

  assign cic_clear        = cic_clear_q;
  assign overrun          = overrun_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;

  // NOTE: all state below uses non-blocking assignments, so later statements
  // in this block override earlier defaults (e.g. an overrun set beats a clear)
  // without any ordering hazard between registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      counter         <= '0;
      settle_cnt      <= '0;
      dec_lat         <= LW'(MAX_DEC_LOG2);
      single_lat      <= 1'b0;
      capture_pending <= 1'b0;
      cic_clear_q     <= 1'b1;
      // NOTE: the capture word is reset too, because its reset value is
      // visible on sample_data; a buffer that is never observed while
      // invalid would not need it.
      data_q          <= '0;
      valid_q         <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      // Defaults: consumer handshake, overrun clear, pending lasts one cycle.
      if (valid_q && smp.sample_ready) valid_q <= 1'b0;
      if (overrun_clr) overrun_q <= 1'b0;
      capture_pending <= 1'b0;

      case (state)
        S_IDLE: begin
          cic_clear_q <= 1'b1;
          counter     <= '0;
          if (enable) begin
            state      <= S_FLUSH;
            dec_lat    <= dec_clamped;
            single_lat <= single_shot;
            settle_cnt <= '0;
            overrun_q  <= 1'b0;
          end
        end

        // Counter doubles as the two-cycle flush timer.
        S_FLUSH: begin
          if (!enable) begin
            state       <= S_IDLE;
            counter     <= '0;
            cic_clear_q <= 1'b1;
          end else if (counter == CW'(1)) begin
            state       <= S_SETTLE;
            counter     <= '0;
            cic_clear_q <= 1'b0;
          end else begin
            counter <= counter + CW'(1);
          end
        end

        S_SETTLE: begin
          if (!enable) begin
            state       <= S_IDLE;
            counter     <= '0;
            cic_clear_q <= 1'b1;
          end else begin
            counter <= counter_step;
            if (dec_strobe) begin
              if (settle_cnt == SW'(SETTLE_SAMPLES-1)) state <= S_RUN;
              else settle_cnt <= settle_cnt + SW'(1);
            end
          end
        end

        // Abort wins over a pending capture: the word is not taken.
        S_RUN: begin
          if (!enable) begin
            state       <= S_IDLE;
            counter     <= '0;
            cic_clear_q <= 1'b1;
          end else begin
            counter <= counter_step;
            if (dec_strobe) capture_pending <= 1'b1;
            if (capture_pending) begin
              if (!valid_q || smp.sample_ready) begin
                data_q  <= cic_data;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              if (single_lat) state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (!enable) begin
            state       <= S_IDLE;
            counter     <= '0;
            cic_clear_q <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          counter     <= '0;
          cic_clear_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cic_sequencer
// Directed bench for cic_sequencer. cic_data is a ramp that changes at each
// falling edge, so the value in cycle n is ramp(edge count n). Expected words
// are pushed into a queue when a run is started; a monitor pops and compares
// each word as it is handed over on the valid/ready channel. Cycle-accurate
// control checks are made from the stimulus process. Cycle n of a run is the
// state after the n-th edge counted from the edge that samples enable=1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_sequencer;

  localparam int MAX_DEC_LOG2 = 8;
  localparam int DW           = 3*MAX_DEC_LOG2+1;
  localparam int LW           = $clog2(MAX_DEC_LOG2+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          single_shot;
  logic [LW-1:0] dec_log2;
  logic [DW-1:0] cic_data;
  logic          cic_clear;
  logic          dec_strobe;
  logic          overrun_clr;
  logic          overrun;
  logic          busy;

  cic_sequencer_if #(.DATA_WIDTH(DW)) smp();

  cic_sequencer #(
    .MAX_DEC_LOG2  (MAX_DEC_LOG2),
    .DATA_WIDTH    (DW),
    .SETTLE_SAMPLES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .single_shot(single_shot),
    .dec_log2   (dec_log2),
    .cic_data   (cic_data),
    .cic_clear  (cic_clear),
    .dec_strobe (dec_strobe),
    .smp        (smp),
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
    .busy       (busy)
  );

  int            edge_n   = 0;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_word;

  function automatic logic [DW-1:0] ramp(input int n);
    return DW'(n * 5 + 3);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;
  always @(negedge clk) cic_data = ramp(edge_n);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Called at a falling edge; edge e (the next rising edge) is cycle 1.
  task automatic start_run(input logic [LW-1:0] dl, input logic ss, output int e);
    dec_log2    = dl;
    single_shot = ss;
    enable      = 1'b1;
    e           = edge_n + 1;
  endtask

  // Advance to the falling edge inside cycle n of the run started at edge e.
  task automatic at_cycle(input int e, input int n);
    while (edge_n < e + n - 1) @(negedge clk);
  endtask

  // Scoreboard monitor: every transferred word must match the queue head.
  always @(negedge clk) begin
    #1;
    if (!reset && smp.sample_valid && smp.sample_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sample_word: actual=%0h expected=<none> (t=%0t)", smp.sample_data, $time);
      end else begin
        mon_word = exp_q.pop_front();
        check("sample_word", 32'(smp.sample_data), 32'(mon_word));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            e;
    int            cnt;
    logic [DW-1:0] kept;

    reset            = 1'b1;
    enable           = 1'b0;
    single_shot      = 1'b0;
    dec_log2         = '0;
    overrun_clr      = 1'b0;
    smp.sample_ready = 1'b1;
    cic_data         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cic_clear", 32'(cic_clear), 32'd1);
    check("rst_strobe",    32'(dec_strobe), 32'd0);
    check("rst_valid",     32'(smp.sample_valid), 32'd0);
    check("rst_data",      32'(smp.sample_data), 32'd0);
    check("rst_overrun",   32'(overrun), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous, D=4: strobes 6,10,14,18,22; valid 20,24,28
    start_run(4'd2, 1'b0, e);
    exp_q.push_back(ramp(e + 18));
    exp_q.push_back(ramp(e + 22));
    exp_q.push_back(ramp(e + 26));
    at_cycle(e, 1);  check("c_busy_flush",   32'(busy), 32'd1);
                     check("c_clear_flush1", 32'(cic_clear), 32'd1);
    at_cycle(e, 2);  check("c_clear_flush2", 32'(cic_clear), 32'd1);
    at_cycle(e, 3);  check("c_clear_settle", 32'(cic_clear), 32'd0);
    at_cycle(e, 5);  check("c_strobe5",  32'(dec_strobe), 32'd0);
    at_cycle(e, 6);  check("c_strobe6",  32'(dec_strobe), 32'd1);
    at_cycle(e, 7);  check("c_strobe7",  32'(dec_strobe), 32'd0);
    at_cycle(e, 10); check("c_strobe10", 32'(dec_strobe), 32'd1);
    at_cycle(e, 14); check("c_strobe14", 32'(dec_strobe), 32'd1);
    at_cycle(e, 18); check("c_strobe18", 32'(dec_strobe), 32'd1);
    at_cycle(e, 19); check("c_valid19",  32'(smp.sample_valid), 32'd0);
    at_cycle(e, 20); check("c_valid20",  32'(smp.sample_valid), 32'd1);
    at_cycle(e, 21); check("c_valid21",  32'(smp.sample_valid), 32'd0);
    at_cycle(e, 22); check("c_strobe22", 32'(dec_strobe), 32'd1);
    at_cycle(e, 24); check("c_valid24",  32'(smp.sample_valid), 32'd1);
    at_cycle(e, 28); enable = 1'b0;
    at_cycle(e, 29); check("c_abort_busy",  32'(busy), 32'd0);
                     check("c_abort_clear", 32'(cic_clear), 32'd1);
    repeat (2) @(negedge clk);

    // Single-shot, D=8: one word, valid at (3+1)*8+4 = 36, then DONE
    start_run(4'd3, 1'b1, e);
    exp_q.push_back(ramp(e + 34));
    at_cycle(e, 10); check("s_strobe10", 32'(dec_strobe), 32'd1);
    at_cycle(e, 34); check("s_strobe34", 32'(dec_strobe), 32'd1);
                     check("s_busy34",   32'(busy), 32'd1);
    at_cycle(e, 35); check("s_valid35",  32'(smp.sample_valid), 32'd0);
    at_cycle(e, 36); check("s_valid36",  32'(smp.sample_valid), 32'd1);
                     check("s_busy_done", 32'(busy), 32'd0);
    cnt = 0;
    for (int c = 36; c <= 60; c++) begin
      at_cycle(e, c);
      cnt += int'(dec_strobe);
    end
    check("s_no_strobes_done", 32'(cnt), 32'd0);
    check("s_clear_done",      32'(cic_clear), 32'd0);
    enable = 1'b0;
    at_cycle(e, 61); check("s_idle_clear", 32'(cic_clear), 32'd1);
    @(negedge clk);
    start_run(4'd3, 1'b1, e);
    exp_q.push_back(ramp(e + 34));
    at_cycle(e, 10); check("s2_strobe10", 32'(dec_strobe), 32'd1);
    at_cycle(e, 36); check("s2_valid36",  32'(smp.sample_valid), 32'd1);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure, D=2: valid 12, captures at edges 14,16 dropped, 18 accepted
    smp.sample_ready = 1'b0;
    start_run(4'd1, 1'b0, e);
    exp_q.push_back(ramp(e + 10));
    at_cycle(e, 10); check("b_strobe10", 32'(dec_strobe), 32'd1);
    at_cycle(e, 11); check("b_valid11",  32'(smp.sample_valid), 32'd0);
    at_cycle(e, 12); check("b_valid12",  32'(smp.sample_valid), 32'd1);
                     check("b_data12",   32'(smp.sample_data), 32'(ramp(e + 10)));
    at_cycle(e, 13); check("b_ovr13",    32'(overrun), 32'd0);
    at_cycle(e, 14); check("b_ovr14",    32'(overrun), 32'd1);
                     check("b_data14",   32'(smp.sample_data), 32'(ramp(e + 10)));
                     overrun_clr = 1'b1;
    at_cycle(e, 15); check("b_ovr_clr15", 32'(overrun), 32'd0);
                     overrun_clr = 1'b0;
    at_cycle(e, 16); check("b_ovr16",    32'(overrun), 32'd1);
                     check("b_data16",   32'(smp.sample_data), 32'(ramp(e + 10)));
                     overrun_clr = 1'b1;
    at_cycle(e, 17); check("b_ovr_clr17", 32'(overrun), 32'd0);
                     overrun_clr = 1'b0;
                     smp.sample_ready = 1'b1;
                     exp_q.push_back(ramp(e + 16));
                     exp_q.push_back(ramp(e + 18));
    at_cycle(e, 18); check("b_ovr18",    32'(overrun), 32'd0);
                     check("b_valid18",  32'(smp.sample_valid), 32'd1);
    at_cycle(e, 20); check("b_valid20",  32'(smp.sample_valid), 32'd1);
                     enable = 1'b0;
    at_cycle(e, 21); check("b_busy21",   32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Abort in RUN with capture pending, then abort in SETTLE
    smp.sample_ready = 1'b0;
    start_run(4'd1, 1'b0, e);
    kept = ramp(e + 10);
    exp_q.push_back(kept);
    at_cycle(e, 12); check("a_valid12", 32'(smp.sample_valid), 32'd1);
    at_cycle(e, 13); enable = 1'b0;
    at_cycle(e, 14); check("a_run_busy",  32'(busy), 32'd0);
                     check("a_run_clear", 32'(cic_clear), 32'd1);
                     check("a_run_valid", 32'(smp.sample_valid), 32'd1);
    at_cycle(e, 16); check("a_run_data",  32'(smp.sample_data), 32'(kept));
                     check("a_run_ovr",   32'(overrun), 32'd0);
    start_run(4'd1, 1'b0, e);
    at_cycle(e, 4);  check("a_set_strobe4", 32'(dec_strobe), 32'd1);
    at_cycle(e, 5);  enable = 1'b0;
    at_cycle(e, 6);  check("a_set_busy",  32'(busy), 32'd0);
                     check("a_set_clear", 32'(cic_clear), 32'd1);
                     check("a_set_data",  32'(smp.sample_data), 32'(kept));
                     smp.sample_ready = 1'b1;
    at_cycle(e, 7);  check("a_drained",   32'(smp.sample_valid), 32'd0);
    repeat (2) @(negedge clk);

    // Clamp and latch: dec_log2=0 -> D=256, change mid-run ignored
    start_run(4'd0, 1'b0, e);
    at_cycle(e, 257); check("p_strobe257", 32'(dec_strobe), 32'd0);
    at_cycle(e, 258); check("p_strobe258", 32'(dec_strobe), 32'd1);
    at_cycle(e, 259); check("p_strobe259", 32'(dec_strobe), 32'd0);
    at_cycle(e, 300); dec_log2 = 4'd1;
    at_cycle(e, 513); check("p_strobe513", 32'(dec_strobe), 32'd0);
    at_cycle(e, 514); check("p_strobe514", 32'(dec_strobe), 32'd1);
                      enable = 1'b0;
    repeat (2) @(negedge clk);
    start_run(4'd9, 1'b0, e);
    at_cycle(e, 257); check("p9_strobe257", 32'(dec_strobe), 32'd0);
    at_cycle(e, 258); check("p9_strobe258", 32'(dec_strobe), 32'd1);
                      enable = 1'b0;
    repeat (2) @(negedge clk);

    // Synchronous reset in RUN with a buffered word (word is lost)
    smp.sample_ready = 1'b0;
    start_run(4'd1, 1'b0, e);
    at_cycle(e, 12); check("r_valid12", 32'(smp.sample_valid), 32'd1);
                     check("r_busy12",  32'(busy), 32'd1);
                     reset  = 1'b1;
                     enable = 1'b0;
    at_cycle(e, 13); check("r_clear",   32'(cic_clear), 32'd1);
                     check("r_strobe",  32'(dec_strobe), 32'd0);
                     check("r_valid",   32'(smp.sample_valid), 32'd0);
                     check("r_data",    32'(smp.sample_data), 32'd0);
                     check("r_overrun", 32'(overrun), 32'd0);
                     check("r_busy",    32'(busy), 32'd0);
                     reset = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
